// File: rtl/rcv_pkg.sv
// Shared types, default parameters and helpers for the serial receiver.
// RCV_PARITY_CHECK_EN adds the PARITY state to the FSM encoding.
`timescale 1ns/1ps
package rcv_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BIT_PERIOD = 10;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int MAX_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef RCV_PARITY_CHECK_EN
    ST_PARITY,
`endif
    ST_STOP
  } rcv_state_e;

  // Even-parity bit of a zero-extended word.
  function automatic logic parity_calc(input logic [MAX_DATA_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rcv_if.sv
// Host/line-side signal bundle of the receiver; slave is the receiver side.
`timescale 1ns/1ps
interface rcv_if #(
  parameter int DATA_WIDTH = rcv_pkg::DEF_DATA_WIDTH
);
  logic                  serial_in;
  logic                  data_read;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  data_ready;
  logic                  overrun_error;
  logic                  framing_error;
  logic                  parity_error;

  modport master (
    output serial_in, data_read,
    input  rx_data, data_ready, overrun_error, framing_error, parity_error
  );

  modport slave (
    input  serial_in, data_read,
    output rx_data, data_ready, overrun_error, framing_error, parity_error
  );
endinterface

// File: rtl/rcv_fifo.sv
// First-word-fall-through receive buffer with a sticky overrun flag.
`timescale 1ns/1ps
module rcv_fifo
  import rcv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ready,
  output logic                  overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_r;
  logic [PTR_W-1:0]      rd_r;
  logic [OCC_W-1:0]      occ_r;
  logic [DATA_WIDTH-1:0] out_r;
  logic                  ready_r;
  logic                  overrun_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  do_pop_s;
  logic                  do_push_s;
  logic                  drop_s;
  logic [OCC_W-1:0]      occ_nxt_s;
  logic [PTR_W-1:0]      rd_nxt_s;
  logic [DATA_WIDTH-1:0] head_nxt_s;

  // Push/pop qualification and next head selection; a pop frees a full slot first.
  always_comb begin
    empty_s    = (occ_r == '0);
    full_s     = (occ_r == FULL_OCC);
    do_pop_s   = pop & ~empty_s;
    do_push_s  = push & (~full_s | do_pop_s);
    drop_s     = push & ~do_push_s;
    occ_nxt_s  = occ_r + OCC_W'(do_push_s) - OCC_W'(do_pop_s);
    rd_nxt_s   = rd_r + PTR_W'(do_pop_s);
    head_nxt_s = mem_r[rd_nxt_s];
    if ((occ_r - OCC_W'(do_pop_s)) == '0) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered head/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_r      <= '0;
      rd_r      <= '0;
      occ_r     <= '0;
      out_r     <= '1;
      ready_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      wr_r    <= wr_r + PTR_W'(do_push_s);
      rd_r    <= rd_nxt_s;
      occ_r   <= occ_nxt_s;
      ready_r <= (occ_nxt_s != '0);
      if (occ_nxt_s != '0) begin
        out_r <= head_nxt_s;
      end
      if (do_pop_s) begin
        overrun_r <= 1'b0;
      end else if (drop_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign rd_data = out_r;
  assign ready   = ready_r;
  assign overrun = overrun_r;

endmodule

// File: rtl/rcv_fifo_block.sv
// Asynchronous serial receiver feeding a word FIFO; reports framing/overrun errors.
// Define RCV_PARITY_CHECK_EN to expect an even-parity bit before the stop bit.
`timescale 1ns/1ps
module rcv_fifo_block
  import rcv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BIT_PERIOD = DEF_BIT_PERIOD,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic  clk,
  input logic  rst,
  rcv_if.slave bus
);

  localparam int CNT_W = $clog2(BIT_PERIOD) + 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);
  // Two cycles of synchroniser latency are already spent when the start is seen.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_PERIOD / 2 - 2);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
`ifdef RCV_PARITY_CHECK_EN
  localparam rcv_state_e AFTER_DATA = ST_PARITY;
`else
  localparam rcv_state_e AFTER_DATA = ST_STOP;
`endif

  logic [1:0]            sync_r;
  logic [1:0]            sync_vld_r;
  logic                  armed_r;
  logic                  rx_s;
  logic                  start_edge_s;
  logic                  tick_s;
  rcv_state_e            state_r;
  rcv_state_e            state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  framing_r;
  logic                  load_half_s;
  logic                  reload_s;
  logic                  shift_en_s;
  logic                  stop_smp_s;
  logic                  clr_err_s;
  logic                  par_bad_s;
  logic                  push_s;

  assign rx_s         = sync_r[1];
  assign start_edge_s = armed_r & ~rx_s;
  assign tick_s       = (cnt_r == '0);

  // Line synchroniser; armed_r only rises after a genuine high sample since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r     <= 2'b11;
      sync_vld_r <= 2'b00;
      armed_r    <= 1'b0;
    end else begin
      sync_r     <= {sync_r[0], bus.serial_in};
      sync_vld_r <= {sync_vld_r[0], 1'b1};
      armed_r    <= sync_vld_r[1] & rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef RCV_PARITY_CHECK_EN
  logic                      par_smp_s;
  logic                      par_bit_r;
  logic [MAX_DATA_WIDTH-1:0] par_ext_s;
`endif

  // FSM next state and per-bit control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_half_s = 1'b0;
    reload_s    = 1'b0;
    shift_en_s  = 1'b0;
    stop_smp_s  = 1'b0;
    clr_err_s   = 1'b0;
`ifdef RCV_PARITY_CHECK_EN
    par_smp_s   = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_nxt_s = ST_START;
          load_half_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && rx_s) begin
          state_nxt_s = ST_IDLE;
        end else if (tick_s) begin
          state_nxt_s = ST_DATA;
          reload_s    = 1'b1;
          clr_err_s   = 1'b1;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          shift_en_s  = 1'b1;
          reload_s    = 1'b1;
          state_nxt_s = (idx_r == LAST_IDX) ? AFTER_DATA : ST_DATA;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
`ifdef RCV_PARITY_CHECK_EN
      ST_PARITY: begin
        if (tick_s) begin
          par_smp_s   = 1'b1;
          reload_s    = 1'b1;
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          stop_smp_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

`ifdef RCV_PARITY_CHECK_EN
  logic parity_r;

  // Even parity over the received word and the sampled parity bit.
  always_comb begin
    par_ext_s                 = '0;
    par_ext_s[DATA_WIDTH-1:0] = shift_r;
    par_bad_s                 = parity_calc(par_ext_s) ^ par_bit_r;
  end

  // Parity bit capture and parity error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit_r <= 1'b0;
      parity_r  <= 1'b0;
    end else begin
      if (par_smp_s) begin
        par_bit_r <= rx_s;
      end
      if (clr_err_s) begin
        parity_r <= 1'b0;
      end else if (stop_smp_s) begin
        parity_r <= parity_r | par_bad_s;
      end
    end
  end

  assign bus.parity_error = parity_r;
`else
  assign par_bad_s        = 1'b0;
  assign bus.parity_error = 1'b0;
`endif

  assign push_s = stop_smp_s & rx_s & ~par_bad_s;

  // Bit timing counter, data shifter and framing error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= '0;
      idx_r     <= '0;
      shift_r   <= '0;
      framing_r <= 1'b0;
    end else begin
      if (load_half_s) begin
        cnt_r <= HALF_LOAD;
      end else if (reload_s) begin
        cnt_r <= FULL_LOAD;
      end else if (!tick_s) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
      if (clr_err_s) begin
        idx_r <= '0;
      end else if (shift_en_s) begin
        idx_r <= idx_r + IDX_W'(1);
      end
      if (shift_en_s) begin
        shift_r <= {rx_s, shift_r[DATA_WIDTH-1:1]};
      end
      if (clr_err_s) begin
        framing_r <= 1'b0;
      end else if (stop_smp_s) begin
        framing_r <= framing_r | ~rx_s;
      end
    end
  end

  assign bus.framing_error = framing_r;

  rcv_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (shift_r),
    .pop       (bus.data_read),
    .rd_data   (bus.rx_data),
    .ready     (bus.data_ready),
    .overrun   (bus.overrun_error)
  );

endmodule

// File: tb/tb_rcv_fifo_block.sv
// Directed bench for rcv_fifo_block at 8 data bits, 10 clocks per bit, 4-deep buffer.
`timescale 1ns/1ps
module tb_rcv_fifo_block;

  logic tb_clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] flags;

  rcv_if #(.DATA_WIDTH(8)) bus ();

  rcv_fifo_block #(
    .DATA_WIDTH (8),
    .BIT_PERIOD (10),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (tb_clk),
    .rst (rst),
    .bus (bus)
  );

  always #1.25 tb_clk = ~tb_clk;

  assign flags = {bus.data_ready, bus.overrun_error, bus.framing_error, bus.parity_error};

  task automatic send_frame(input logic [7:0] data, input realtime bit_ns, input logic stop_bit);
    @(negedge tb_clk);
    bus.serial_in = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      bus.serial_in = data[i];
      #(bit_ns);
    end
`ifdef RCV_PARITY_CHECK_EN
    bus.serial_in = ^data;
    #(bit_ns);
`endif
    bus.serial_in = stop_bit;
    #(bit_ns);
    bus.serial_in = 1'b1;
    #(2.0 * bit_ns);
  endtask

  task automatic pop_word();
    @(negedge tb_clk);
    bus.data_read = 1'b1;
    @(negedge tb_clk);
    bus.data_read = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.serial_in = 1'b1;
    bus.data_read = 1'b0;
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    total++;
    if (bus.rx_data !== 8'hFF) begin
      bad++;
      $display("FAIL reset_rx_data: got %h want ff", bus.rx_data);
    end
    total++;
    if (flags !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", flags);
    end
    rst = 1'b0;
    pop_word();
    total++;
    if ({bus.rx_data, flags} !== {8'hFF, 4'b0000}) begin
      bad++;
      $display("FAIL empty_pop: got %h/%b want ff/0000", bus.rx_data, flags);
    end
    repeat (4) @(negedge tb_clk);
  endtask

  task automatic test_normal_frame();
    send_frame(8'hD5, 25.0, 1'b1);
    @(negedge tb_clk);
    total++;
    if ({bus.rx_data, flags} !== {8'hD5, 4'b1000}) begin
      bad++;
      $display("FAIL normal_rx: got %h/%b want d5/1000", bus.rx_data, flags);
    end
    pop_word();
    total++;
    if ({bus.rx_data, flags} !== {8'hD5, 4'b0000}) begin
      bad++;
      $display("FAIL normal_pop: got %h/%b want d5/0000", bus.rx_data, flags);
    end
  endtask

  task automatic test_rate_tolerance();
    realtime rates [2];
    rates[0] = 24.0;
    rates[1] = 26.0;
    for (int r = 0; r < 2; r++) begin
      send_frame(8'hD5, rates[r], 1'b1);
      @(negedge tb_clk);
      total++;
      if ({bus.rx_data, flags} !== {8'hD5, 4'b1000}) begin
        bad++;
        $display("FAIL rate_%0d: got %h/%b want d5/1000", r, bus.rx_data, flags);
      end
      pop_word();
      total++;
      if (bus.data_ready !== 1'b0) begin
        bad++;
        $display("FAIL rate_pop_%0d: got %b want 0", r, bus.data_ready);
      end
    end
  endtask

  task automatic test_framing();
    send_frame(8'hD5, 25.0, 1'b0);
    @(negedge tb_clk);
    total++;
    if ({bus.rx_data, flags} !== {8'hD5, 4'b0010}) begin
      bad++;
      $display("FAIL framing_set: got %h/%b want d5/0010", bus.rx_data, flags);
    end
    send_frame(8'h3C, 25.0, 1'b1);
    @(negedge tb_clk);
    total++;
    if ({bus.rx_data, flags} !== {8'h3C, 4'b1000}) begin
      bad++;
      $display("FAIL framing_clear: got %h/%b want 3c/1000", bus.rx_data, flags);
    end
    pop_word();
  endtask

  task automatic test_overrun();
    logic [7:0] exp_rx;
    logic [3:0] exp_flags;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 25.0, 1'b1);
    end
    @(negedge tb_clk);
    total++;
    if ({bus.rx_data, flags} !== {8'h01, 4'b1100}) begin
      bad++;
      $display("FAIL overrun_set: got %h/%b want 01/1100", bus.rx_data, flags);
    end
    for (int j = 1; j <= 4; j++) begin
      pop_word();
      exp_rx    = (j < 4) ? 8'(j + 1) : 8'h04;
      exp_flags = (j < 4) ? 4'b1000 : 4'b0000;
      total++;
      if ({bus.rx_data, flags} !== {exp_rx, exp_flags}) begin
        bad++;
        $display("FAIL overrun_pop_%0d: got %h/%b want %h/%b", j, bus.rx_data, flags, exp_rx, exp_flags);
      end
    end
  endtask

  task automatic test_glitch();
    @(negedge tb_clk);
    bus.serial_in = 1'b0;
    #6.0;
    bus.serial_in = 1'b1;
    #300.0;
    @(negedge tb_clk);
    total++;
    if ({bus.rx_data, flags} !== {8'h04, 4'b0000}) begin
      bad++;
      $display("FAIL glitch: got %h/%b want 04/0000", bus.rx_data, flags);
    end
  endtask

`ifdef RCV_PARITY_CHECK_EN
  task automatic test_parity();
    logic [7:0] d;
    d = 8'hD5;
    @(negedge tb_clk);
    bus.serial_in = 1'b0;
    #25.0;
    for (int i = 0; i < 8; i++) begin
      bus.serial_in = d[i];
      #25.0;
    end
    bus.serial_in = 1'b0;
    #25.0;
    bus.serial_in = 1'b1;
    #75.0;
    @(negedge tb_clk);
    total++;
    if (flags !== 4'b0001) begin
      bad++;
      $display("FAIL parity_set: got %b want 0001", flags);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_normal_frame();
    test_rate_tolerance();
    test_framing();
    test_overrun();
    test_glitch();
`ifdef RCV_PARITY_CHECK_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rcv_fifo_block.md
# rcv_fifo_block

Parametrised serial receiver that deserialises an asynchronous start/data/stop frame into a configurable-width word and buffers received words in an internal FIFO. It generalises the fixed 8-bit, single-register receiver:
- data width, bit period and buffer depth are parameters;
- framing, overrun and optional parity errors are reported.

The block sits between the external serial line and the host-side register interface, which drains words with `data_read`.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, LSB first; legal 5..16.
- `BIT_PERIOD`, 10: `clk` cycles per serial bit; legal >= 4.
- `FIFO_DEPTH`, 4: buffered words; power of 2, >= 2.
- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `serial_in` in 1: asynchronous serial line; idle high.
- `data_read` in 1: pop request for the FIFO head word.
- `rx_data` out `DATA_WIDTH`: FIFO head word.
- `data_ready` out 1: FIFO non-empty.
- `overrun_error` out 1: a valid frame was dropped because the FIFO was full.
- `framing_error` out 1: the most recent frame had stop bit = 0.
- `parity_error` out 1: the most recent frame failed the parity check; tied 0 when parity is compiled out.

## Operation
- **Input synchroniser.** `serial_in` passes through a 2-flop synchroniser that resets to 1. A start edge is a synchronised 1->0 transition seen in IDLE.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on start edge. The bit counter loads so the first sample lands at `BIT_PERIOD/2` cycles, which is mid start bit.
  - In START, a mid-bit sample of 1 is a false start: go to IDLE with no flag change. A sample of 0 goes to DATA.
  - In DATA, sample every `BIT_PERIOD` cycles and shift in LSB first. After `DATA_WIDTH` samples, go to PARITY if compiled in, otherwise STOP.
  - In PARITY, take one sample, then go to STOP.
  - In STOP, take the mid-bit sample, then return to IDLE on the same cycle. This allows back-to-back frames at +/-4% rate error.
- **Stop sample outcomes:**
  - Stop = 0: set `framing_error`; no push.
  - Parity mismatch: set `parity_error`; no push.
  - Both errors can set together.
  - Otherwise: push the word to the FIFO.
- **Error flag lifetime:**
  - `framing_error` and `parity_error` clear on the next accepted start, i.e. START -> DATA.
  - `overrun_error` is sticky and clears on any cycle where `data_read`=1 and the FIFO is non-empty.
- **FIFO behaviour:**
  - First-word-fall-through: `rx_data` = head entry while non-empty.
  - When empty, `rx_data` holds the last value it showed.
  - `data_read` on an empty FIFO is ignored.
  - A push while full drops the word and sets `overrun_error`.
  - A push and pop on the same cycle while full: the pop takes effect first, the push is accepted, and no overrun is flagged.
  - Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. Occupancy uses one extra bit to distinguish full from empty.
- **Reset mid-frame:** the FSM returns to IDLE, the FIFO empties and the partial word is discarded. A line that is still low after reset is not treated as a start edge until it has returned high.
- **Bit counter width:** `$clog2(BIT_PERIOD)+1`.

## Timing
- Reset values:
  - `rx_data` = all ones.
  - `data_ready`, `overrun_error`, `framing_error`, `parity_error` = 0.
  - FSM in IDLE; synchroniser outputs 1.
- Start edge detection: 2 cycles of synchroniser latency after the line falls.
- Stop-bit sample to output update: `data_ready` or an error flag rises 1 cycle after the stop sample cycle.
- Pop: `data_read` high at edge N updates `rx_data` and `data_ready` after edge N. The host holds `data_read` for exactly 1 cycle per word.
- Frame length: (1 + `DATA_WIDTH` + parity + 1) × `BIT_PERIOD` cycles.

## Configuration
- Macro: `RCV_PARITY_CHECK_EN`.
- Defined:
  - The PARITY state exists and one parity bit is expected between the last data bit and the stop bit.
  - Even parity: XOR of data bits and parity bit must be 0; otherwise `parity_error` is set.
- Undefined:
  - The PARITY state is absent, frames have no parity bit, and `parity_error` is driven constant 0.

## Structure
- Package `rcv_pkg` holds:
  - the FSM state enum typedef;
  - default constants for `DATA_WIDTH`, `BIT_PERIOD` and `FIFO_DEPTH`;
  - a `parity_calc` function.
- Sub-module `rcv_fifo`, parametrised by `DATA_WIDTH` and `FIFO_DEPTH`. It owns the push/pop/full/empty logic and the overrun flag.

## Test plan
All scenarios use default parameters with `BIT_PERIOD` = 10 cycles at a 2.5 ns clock.

- Reset: assert `rst` for 2 cycles -> `rx_data` = 0xFF and all flags 0.
- Normal frame: send 0xD5 with stop = 1 at a 25 ns bit period; wait 2 bits -> `rx_data` = 0xD5, `data_ready` = 1, no errors; pulse `data_read` -> `data_ready` = 0 one cycle later.
- Rate tolerance: send 0xD5 at 24 ns, then at 26 ns per bit -> both received correctly, no errors.
- Framing error: send 0xD5 with stop = 0 -> `framing_error` = 1 and `data_ready` = 0; a following valid 0x3C clears `framing_error` and is delivered.
- Buffering and overrun: send 5 frames 0x01..0x05 with no reads ->
  - `overrun_error` = 1;
  - 4 pops return 0x01..0x04 in order;
  - the first pop clears `overrun_error`;
  - the 0x05 frame was dropped.
- Noise and parity: a 1-bit-period/4 low glitch on `serial_in` is a false start, giving no push and no flags. With `RCV_PARITY_CHECK_EN` defined, 0xD5 with parity bit 0 sets `parity_error` = 1 and does not push.
